// File: rtl/pzc_div_scheduler.sv
// Round-robin scheduler feeding N_CH signed PZC samples through one shared
// restoring divider; each result is sample/PZC_M_FACTOR >>> OUT_SHIFT.
module pzc_div_scheduler #(
  parameter int N_CH         = 4,
  parameter int DIN_W        = 46,
  parameter int PZC_M_FACTOR = 454,
  parameter int OUT_SHIFT    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       ch_valid,
  input  logic [N_CH*DIN_W-1:0] ch_data,
  output logic [N_CH-1:0]       ch_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIN_W-1:0]      out_data,
  output logic [2:0]            out_ch,
  output logic                  busy
);

  localparam int PTR_W = (N_CH > 2) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(DIN_W + 1);
  localparam int REM_W = 16;

  typedef enum logic [1:0] {IDLE, DIV, FIX, OUT} state_t;

  state_t                   state, state_nx;
  logic [PTR_W-1:0]         rr_ptr;
  logic [CNT_W-1:0]         cnt;
  logic [DIN_W-1:0]         quo;
  logic [REM_W-1:0]         rem;
  logic                     neg;
  logic [2:0]               cur_ch;

  logic                     gnt_any;
  logic [2:0]               gnt_idx;
  logic [PTR_W:0]           rr_sum;
  logic                     accept;
  logic signed [DIN_W-1:0]  sel_data;
  logic [REM_W:0]           rem_sh;
  logic [REM_W-1:0]         rem_sub;
  logic                     take;
  logic signed [DIN_W-1:0]  sq;

  // First asserted request at or after rr_ptr, wrapping at N_CH.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    for (int off = 0; off < N_CH; off++) begin
      rr_sum = {1'b0, rr_ptr} + (PTR_W+1)'(off);
      if (rr_sum >= (PTR_W+1)'(N_CH))
        rr_sum = rr_sum - (PTR_W+1)'(N_CH);
      if (!gnt_any && ch_valid[rr_sum[PTR_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = 3'(rr_sum[PTR_W-1:0]);
      end
    end
  end

  assign accept   = (state == IDLE) && gnt_any;
  assign sel_data = ch_data[int'(gnt_idx)*DIN_W +: DIN_W];

  // One restoring step per cycle; remainder always stays below the divisor.
  assign rem_sh  = {rem, quo[DIN_W-1]};
  assign take    = rem_sh >= (REM_W+1)'(PZC_M_FACTOR);
  assign rem_sub = rem_sh[REM_W-1:0] - REM_W'(PZC_M_FACTOR);
  assign sq      = neg ? -$signed(quo) : $signed(quo);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = DIV;
      DIV:  if (cnt == CNT_W'(DIN_W-1)) state_nx = FIX;
      FIX:  state_nx = OUT;
      OUT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ch_ready  = '0;
    if (state == IDLE && gnt_any)
      ch_ready = N_CH'(1) << gnt_idx;
    out_valid = (state == OUT);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      neg      <= 1'b0;
      cur_ch   <= '0;
      out_data <= '0;
      out_ch   <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          // Magnitude in DIN_W unsigned bits, so the most negative sample is exact.
          neg    <= sel_data[DIN_W-1];
          quo    <= sel_data[DIN_W-1] ? DIN_W'(-sel_data) : DIN_W'(sel_data);
          rem    <= '0;
          cnt    <= '0;
          cur_ch <= gnt_idx;
          rr_ptr <= (gnt_idx == 3'(N_CH-1)) ? '0 : PTR_W'(gnt_idx + 3'd1);
        end
        DIV: begin
          rem <= take ? rem_sub : rem_sh[REM_W-1:0];
          quo <= {quo[DIN_W-2:0], take};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          out_data <= sq >>> OUT_SHIFT;
          out_ch   <= cur_ch;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pzc_div_scheduler.sv
// Directed scoreboard bench for pzc_div_scheduler: arithmetic, latency,
// round-robin order, backpressure and mid-operation reset.
module tb_pzc_div_scheduler;
  localparam int N_CH  = 4;
  localparam int DIN_W = 46;
  localparam int M     = 454;
  localparam int SH    = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       ch_valid;
  logic [N_CH*DIN_W-1:0] ch_data;
  logic [N_CH-1:0]       ch_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIN_W-1:0]      out_data;
  logic [2:0]            out_ch;
  logic                  busy;

  typedef struct {
    int               ch;
    logic [DIN_W-1:0] data;
  } exp_t;

  exp_t   sb[$];
  longint samp[N_CH];
  int     rr_m;
  int     checks = 0;
  int     errors = 0;

  pzc_div_scheduler #(.N_CH(N_CH), .DIN_W(DIN_W), .PZC_M_FACTOR(M), .OUT_SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DIN_W-1:0] model(input longint s);
    longint q;
    q = s / M;
    q = q >>> SH;
    return q[DIN_W-1:0];
  endfunction

  function automatic int pick(input logic [N_CH-1:0] v);
    for (int off = 0; off < N_CH; off++)
      if (v[(rr_m + off) % N_CH]) return (rr_m + off) % N_CH;
    return -1;
  endfunction

  task automatic drive_data();
    for (int i = 0; i < N_CH; i++) ch_data[i*DIN_W +: DIN_W] = samp[i][DIN_W-1:0];
  endtask

  task automatic scramble_data();
    for (int i = 0; i < N_CH; i++) ch_data[i*DIN_W +: DIN_W] = DIN_W'({$urandom(), $urandom()});
  endtask

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    rr_m = 0;
  endtask

  // Called at a negedge with the DUT idle; one full request-to-transfer cycle.
  task automatic serve(input logic [N_CH-1:0] v, input bit keep, input bit bp);
    int n, g;
    exp_t e;
    logic [DIN_W-1:0] d0;
    logic [2:0] c0;
    drive_data();
    ch_valid  = v;
    out_ready = !bp;
    #1;
    g = pick(v);
    chk("grant", ch_ready, 64'(1 << g));
    sb.push_back('{g, model(samp[g])});
    rr_m = (g + 1) % N_CH;
    @(posedge clk);
    @(negedge clk);
    scramble_data();
    if (!keep) ch_valid = '0;
    chk("busy_div", busy, 1);
    chk("ready_div", ch_ready, 0);
    n = 0;
    while (out_valid !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, DIN_W + 1);
    e = sb.pop_front();
    chk("out_data", out_data, e.data);
    chk("out_ch", out_ch, e.ch);
    if (bp) begin
      d0 = out_data;
      c0 = out_ch;
      repeat (20) begin
        @(negedge clk);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, d0);
        chk("bp_ch", out_ch, c0);
        chk("bp_ready", ch_ready, 0);
        chk("bp_busy", busy, 1);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_valid", out_valid, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    ch_valid  = '0;
    ch_data   = '0;
    out_ready = 1'b1;
    rr_m      = 0;
    foreach (samp[i]) samp[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ch_ready, 0);
    rst = 1'b0;

    // Exact multiple of the divisor and shift.
    samp[0] = 464896;
    serve(4'b0001, 1'b0, 1'b0);

    // Sign handling and rounding at the boundaries.
    samp[1] = -453;
    serve(4'b0010, 1'b0, 1'b0);
    samp[2] = -454;
    serve(4'b0100, 1'b0, 1'b0);
    samp[3] = -464896;
    serve(4'b1000, 1'b0, 1'b0);
    samp[0] = -(64'sd1 <<< 45);
    serve(4'b0001, 1'b0, 1'b0);
    samp[1] = (64'sd1 <<< 45) - 1;
    serve(4'b0010, 1'b0, 1'b0);

    // Backpressure holds the result.
    samp[2] = 123456789;
    serve(4'b0100, 1'b0, 1'b1);

    // Round-robin with every channel requesting from reset.
    samp[0] = 1000000;
    samp[1] = -2000000;
    samp[2] = 30000000;
    samp[3] = -400000000;
    ch_valid = 4'b1111;
    pulse_rst();
    repeat (5) serve(4'b1111, 1'b1, 1'b0);

    // Reset mid-DIV discards the operation and rewinds the pointer.
    drive_data();
    ch_valid = 4'b0010;
    #1;
    chk("mid_grant", ch_ready, 4'b0010);
    @(posedge clk);
    repeat (10) @(posedge clk);
    pulse_rst();
    chk("mid_busy", busy, 0);
    chk("mid_valid", out_valid, 0);
    chk("mid_data", out_data, 0);
    ch_valid = '0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    chk("mid_no_out", seen, 0);
    samp[0] = 908;
    samp[2] = 7777777;
    serve(4'b0101, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
